square_iter: RTL and testbench

Parametrised, multi-cycle shift-add squarer with valid/ready handshakes on both sides. It replaces the single-cycle 16-bit array squarer in the square-root datapath. The sqrt search loop feeds it candidate roots and compares the returned square against the radicand. Throughput and area are traded through `BITS_PER_CYCLE`, and an optional signed mode squares two's-complement operands.

---
 rtl/square_iter.sv | 108 ++++++++++
 tb/tb_square_iter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/square_iter.sv
// square_iter: multi-cycle shift-add squarer with valid/ready on both sides.
// On accept it captures the operand magnitude. Each CALC cycle then folds
// BITS_PER_CYCLE multiplier bits into a 2*WIDTH accumulator. The result is
// presented in DONE and held until the next result overwrites it.
//
// state | meaning
// IDLE  | ready for an operand, no result pending
// CALC  | consuming BITS_PER_CYCLE multiplier bits per cycle
// DONE  | result valid, waiting for downstream ready
module square_iter #(
  parameter int WIDTH          = 16,
  parameter int BITS_PER_CYCLE = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  logic [WIDTH-1:0]     num_i,
  input  logic                 signed_i,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic [2*WIDTH-1:0]   num_2_o
);

  localparam int STEPS = WIDTH / BITS_PER_CYCLE;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(STEPS - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]           state;
  logic [WIDTH-1:0]     mult;
  // Multiplicand pre-shifted by step*BITS_PER_CYCLE, so no variable shifter is needed.
  logic [2*WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0]   acc;
  logic [CW-1:0]        step;
  logic [WIDTH-1:0]     mag;
  logic [2*WIDTH-1:0]   pp;
  logic [2*WIDTH-1:0]   acc_next;

  // Operand magnitude; the most negative value maps to 2^(WIDTH-1), which still fits.
  always_comb begin
    mag = num_i;
    if (signed_i && num_i[WIDTH-1]) begin
      mag = (~num_i) + 1'b1;
    end
  end

  // Partial product for the low multiplier bits, added onto the running sum.
  always_comb begin
    pp = '0;
    for (int j = 0; j < BITS_PER_CYCLE; j++) begin
      if (mult[j]) begin
        pp = pp + (mcand << j);
      end
    end
    acc_next = acc + pp;
  end

  // Sequencing FSM with the shift-add datapath and the held result register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state   <= S_IDLE;
      mult    <= '0;
      mcand   <= '0;
      acc     <= '0;
      step    <= '0;
      num_2_o <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (valid_i) begin
            mult  <= mag;
            mcand <= {{WIDTH{1'b0}}, mag};
            acc   <= '0;
            step  <= '0;
            state <= S_CALC;
          end
        end
        S_CALC: begin
          acc   <= acc_next;
          mult  <= mult >> BITS_PER_CYCLE;
          mcand <= mcand << BITS_PER_CYCLE;
          step  <= step + 1'b1;
          if (step == LAST_STEP) begin
            num_2_o <= acc_next;
            state   <= S_DONE;
          end
        end
        S_DONE: begin
          if (ready_i) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Handshake outputs come from the registered state only.
  always_comb begin
    ready_o = (state == S_IDLE);
    valid_o = (state == S_DONE);
  end

endmodule

// File: tb/tb_square_iter.sv
// Bench for square_iter: twelve parameter configurations run in parallel,
// each with directed corners, a mid-computation reset and random operands.
// Expected squares come from plain 64-bit arithmetic on the operand magnitude.
module tb_square_iter;

  localparam int NCFG   = 12;
  localparam int N_RAND = 300;

  logic clk;
  int   cyc;
  int   n_pass;
  int   n_total;
  logic [NCFG-1:0] done_vec;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input int id, input string name,
                       input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL cfg%0d %s: got %0h expected %0h", id, name, got, exp);
  endtask

  // Square of the operand read as a w-bit value, optionally two's-complement.
  function automatic logic [63:0] ref_sq(input logic [63:0] n, input logic sg, input int w);
    logic [63:0] v;
    logic [63:0] mag;
    v = n & ((64'd1 << w) - 64'd1);
    if (sg && v[w-1]) mag = (64'd1 << w) - v;
    else mag = v;
    return mag * mag;
  endfunction

  for (genvar g = 0; g < NCFG; g++) begin : cfg
    localparam int W     = 4 << (g / 3);
    localparam int B     = 1 << (g % 3);
    localparam int STEPS = W / B;

    logic             rst_n;
    logic             valid_i;
    logic             ready_o;
    logic [W-1:0]     num_i;
    logic             signed_i;
    logic             valid_o;
    logic             ready_i;
    logic [2*W-1:0]   num_2_o;
    logic             done;

    logic [63:0]      exp_q[$];
    int               acc_q[$];
    logic             prev_v;
    logic             prev_hs;
    logic [2*W-1:0]   prev_num;
    logic [63:0]      last_res;

    assign done_vec[g] = done;

    square_iter #(.WIDTH(W), .BITS_PER_CYCLE(B)) dut (
      .clk_i    (clk),
      .rst_ni   (rst_n),
      .valid_i  (valid_i),
      .ready_o  (ready_o),
      .num_i    (num_i),
      .signed_i (signed_i),
      .valid_o  (valid_o),
      .ready_i  (ready_i),
      .num_2_o  (num_2_o)
    );

    // Monitor: record accepts, check results, latency, hold and handshake timing.
    always @(negedge clk) begin
      logic [63:0] e;
      int a;
      if (!rst_n) begin
        exp_q.delete();
        acc_q.delete();
        prev_v   = 1'b0;
        prev_hs  = 1'b0;
        last_res = '0;
      end else begin
        if (valid_i && ready_o) begin
          exp_q.push_back(ref_sq(64'(num_i), signed_i, W));
          acc_q.push_back(cyc + 1);
        end
        if (valid_o && !prev_v) begin
          check(g, "result_expected", 64'(exp_q.size() != 0), 64'd1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            a = acc_q.pop_front();
            check(g, "square", 64'(num_2_o), e);
            check(g, "latency", 64'(cyc - a), 64'(STEPS));
            last_res = e;
          end
        end else if (valid_o) begin
          check(g, "hold_in_done", 64'(num_2_o), 64'(prev_num));
          check(g, "ready_in_done", 64'(ready_o), 64'd0);
        end else begin
          check(g, "result_hold", 64'(num_2_o), last_res);
        end
        if (prev_hs) check(g, "ready_after_hs", 64'({ready_o, valid_o}), 64'b10);
        prev_v   = valid_o;
        prev_hs  = valid_o && ready_i;
        prev_num = num_2_o;
      end
    end

    task automatic accept_op(input logic [W-1:0] n, input logic s);
      int   t;
      logic acc;
      valid_i  = 1'b1;
      num_i    = n;
      signed_i = s;
      t   = 0;
      acc = 1'b0;
      while (!acc && t < 1000) begin
        @(negedge clk);
        acc = ready_o;
        @(posedge clk);
        #1;
        t++;
      end
      valid_i  = 1'b0;
      num_i    = W'($urandom);
      signed_i = 1'($urandom);
      check(g, "accepted", 64'(acc), 64'd1);
    endtask

    task automatic do_op(input logic [W-1:0] n, input logic s, input logic r, input int bp);
      int t;
      ready_i = r;
      accept_op(n, s);
      t = 0;
      while (!valid_o && t < 300) begin
        num_i    = W'($urandom);
        signed_i = 1'($urandom);
        valid_i  = ($urandom % 3) == 0;
        @(posedge clk);
        #1;
        t++;
      end
      valid_i = 1'b0;
      check(g, "valid_seen", 64'(valid_o), 64'd1);
      if (!r) begin
        repeat (bp) begin
          @(posedge clk);
          #1;
        end
        ready_i = 1'b1;
      end
      @(posedge clk);
      #1;
    endtask

    // Driver: corners, backpressure, mid-computation reset, then random operands.
    initial begin
      logic [W-1:0] all1;
      logic [W-1:0] msb;
      int rw;
      done     = 1'b0;
      rst_n    = 1'b0;
      valid_i  = 1'b0;
      ready_i  = 1'b1;
      num_i    = '0;
      signed_i = 1'b0;
      all1     = '1;
      msb      = all1 ^ (all1 >> 1);
      repeat (2) @(posedge clk);
      #1;
      check(g, "reset_handshake", 64'({ready_o, valid_o}), 64'b10);
      check(g, "reset_num", 64'(num_2_o), 64'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      do_op('0, 1'b0, 1'b1, 0);
      do_op(W'(1), 1'b0, 1'b1, 0);
      do_op(all1, 1'b0, 1'b1, 0);
      do_op(all1, 1'b1, 1'b1, 0);
      do_op(msb, 1'b1, 1'b0, 5);
      do_op(all1 - W'(2), 1'b1, 1'b1, 0);
      do_op(all1 - W'(2), 1'b0, 1'b0, 2);
      do_op(W'(1), 1'b1, 1'b1, 0);
      do_op(msb, 1'b0, 1'b1, 0);

      rw = (STEPS > 3) ? 3 : STEPS - 1;
      ready_i = 1'b1;
      accept_op(W'(1234), 1'b0);
      repeat (rw) begin
        @(posedge clk);
        #1;
      end
      rst_n = 1'b0;
      #1;
      check(g, "midreset_handshake", 64'({ready_o, valid_o}), 64'b10);
      check(g, "midreset_num", 64'(num_2_o), 64'd0);
      @(negedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      do_op(W'(5), 1'b0, 1'b1, 0);

      for (int i = 0; i < N_RAND; i++) begin
        do_op(W'($urandom), 1'($urandom), ($urandom % 4) != 0, $urandom_range(1, 4));
      end
      repeat (3) @(posedge clk);
      #1;
      check(g, "queue_empty", 64'(exp_q.size()), 64'd0);
      done = 1'b1;
    end
  end

  initial begin
    int t;
    t = 0;
    while (done_vec != '1 && t < 60000) begin
      @(posedge clk);
      t++;
    end
    check(-1, "all_done", 64'(done_vec), 64'((1 << NCFG) - 1));
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
